ts_result_collector: RTL and testbench
======================================

# ts_result_collector

Downstream stage of the tensor slice wrapper. It captures each 128-bit result word presented with the one-cycle `c_data_available` strobe and buffers it in a small FIFO. Each word is serialized into two 64-bit beats on a valid/ready master stream, and `m_tlast` marks the end of every `BURST_LEN`-result burst. The block decouples the slice's fire-and-forget result strobe from a back-pressured consumer such as a DMA or stream switch.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries of 128 bits; power of two, ≥2
- `BURST_LEN`, 8: results per burst; `m_tlast` asserts on the final beat of result `BURST_LEN-1`; ≥1

Ports:
- `ap_clk` in 1: the single clock; all state updates on the rising edge
- `ap_rst` in 1: reset, asynchronous and active-high
- `ap_ce` in 1: clock enable; when low, all state holds
- `c_data_in` in 128: result word from the tensor slice
- `c_data_available` in 1: capture strobe, one cycle per result
- `m_tdata` out 64: stream beat data
- `m_tvalid` out 1: beat valid
- `m_tready` in 1: consumer ready
- `m_tlast` out 1: last beat of burst
- `fifo_level` out $clog2(DEPTH)+1: occupied entries, 0..DEPTH
- `ovf` out 1: sticky overflow flag; present only with `TS_COLLECT_OVF_EN`

## Operation
- **Push.** Push occurs when `ap_ce && c_data_available` and the FIFO can accept the word. The word is written at the write pointer, which then increments modulo DEPTH.
- **Accept condition.** The FIFO accepts a word when it is not full, or when it is full and the head entry pops in the same cycle.
- **Drop.** A word arriving while the FIFO is full with no same-cycle pop is dropped. FIFO contents are unchanged.
- **Beat order.** Beats leave the head entry low half first: `[63:0]`, then `[127:64]`. An internal `half` bit selects the half.
  - A beat is accepted when `ap_ce && m_tvalid && m_tready`.
  - On an accepted low beat, `half` goes to 1.
  - On an accepted high beat, `half` goes to 0, the head pops, and the read pointer increments modulo DEPTH.
- **Valid and data.**
  - `m_tvalid` = `ap_ce && (fifo_level != 0)`. It is forced low while `ap_ce` is low, so no beat transfers while the block is stalled.
  - `m_tdata` = selected half of the head entry. It is driven from storage registers with no added pipeline stage.
- **Burst counter.** `rcnt` runs 0..BURST_LEN-1 and increments on each pop. It wraps to 0 on the pop where `rcnt == BURST_LEN-1`.
- **Last.** `m_tlast` = `m_tvalid && half && (rcnt == BURST_LEN-1)`.
- **Level.** `fifo_level` = push − pop accounting.
  - Simultaneous push and pop leave the level unchanged.
  - Full is `fifo_level == DEPTH`. Pointers carry one extra wrap bit, or the level register is used directly.
- **Stable beat.** Once `m_tvalid` is high, `m_tdata` and `m_tlast` hold stable until the beat is accepted. This holds while `ap_ce` stays high.

## Timing
- **Reset values.** On `ap_rst`, asynchronously:
  - pointers, `half`, `rcnt`, `fifo_level` = 0
  - storage = 0
  - `m_tvalid` = 0, `m_tdata` = 0, `m_tlast` = 0, `ovf` = 0
- **Latency.** A strobe at edge N into an empty FIFO gives `m_tvalid` = 1 with the low half valid after edge N.
- **Throughput.** Peak is one result per 2 cycles. Sustained strobes faster than that fill the FIFO.
- **Back-to-back with ready high.** Beats run L0, H0, L1, H1, … with no bubble between entries.
- **Empty FIFO.** A push into an empty FIFO never pops in the same cycle, because `m_tvalid` was low. No bypass path exists.
- **Reset mid-burst.** All in-flight data and the `rcnt` phase are discarded. The next result starts a new burst at `rcnt` = 0.
- **`ap_ce` low.** A `c_data_available` strobe during `ap_ce` = 0 is ignored: not captured and not counted as overflow.

## Configuration
- **`TS_COLLECT_OVF_EN` defined:**
  - The `ovf` port exists.
  - `ovf` is set on any dropped word and stays set until `ap_rst`.
- **`TS_COLLECT_OVF_EN` not defined:**
  - No `ovf` port and no flag register.
  - Dropped words are discarded silently.
  - All other behaviour is identical.

## Test plan
- **Single result.** After reset, strobe `c_data_in` = 128'h1111…_2222… once with `m_tready` = 1. Expect `m_tdata` = 64'h2222… then 64'h1111… on consecutive cycles, `m_tlast` = 0, and `fifo_level` back to 0.
- **Burst framing.** With BURST_LEN = 8, send 16 results at one per 2 cycles with ready high. Expect `m_tlast` only on beats 16 and 32, and data in order.
- **Back-pressure fill.** Hold `m_tready` = 0 and send 4 results with DEPTH = 4. Expect `fifo_level` = 4. A 5th strobe is dropped and `ovf` = 1 (macro on). Release ready: exactly 8 beats of the first 4 results.
- **Full with simultaneous pop.** With the FIFO full, the high beat of the head is accepted in the same cycle as a new strobe. Expect the word to be accepted, `fifo_level` to stay 4, and `ovf` to stay 0.
- **`ap_ce` gating.** Drop `ap_ce` mid-entry after the low beat. Expect `m_tvalid` = 0 and a strobe ignored. Raise `ap_ce`: the high beat of the same entry follows.
- **Async reset.** Assert `ap_rst` between edges with 3 entries queued. Expect all outputs 0 immediately. The next result restarts with `m_tlast` at result 8.

Source files
------------

// File: rtl/ts_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : ts_result_collector
// Description : Captures 128-bit tensor-slice results on a one-cycle strobe,
//               buffers them in a DEPTH-entry FIFO and serializes each word
//               into two 64-bit beats (low half first) on a valid/ready
//               stream. m_tlast marks the final beat of every BURST_LEN-result
//               burst. Optional sticky overflow flag: define TS_COLLECT_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_result_collector #(
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_ce,
  input  logic [127:0]              c_data_in,
  input  logic                      c_data_available,
  output logic [63:0]               m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [$clog2(DEPTH):0]    fifo_level
`ifdef TS_COLLECT_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int RCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [LW-1:0]  FULL_LEVEL = LW'(DEPTH);
  localparam logic [RCW-1:0] RCNT_LAST  = RCW'(BURST_LEN - 1);

  logic [127:0]   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           half_q, half_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  logic           beat_acc;
  logic           pop;
  logic           push;
  logic           full;
  logic [127:0]   head;

`ifdef TS_COLLECT_OVF_EN
  logic           ovf_q, ovf_d;
  logic           drop;
`endif

  // Stream outputs come straight from storage; valid is masked by the clock enable
  always_comb begin
    head       = mem_q[rptr_q];
    m_tvalid   = ap_ce && (level_q != '0);
    m_tdata    = half_q ? head[127:64] : head[63:0];
    m_tlast    = m_tvalid && half_q && (rcnt_q == RCNT_LAST);
    fifo_level = level_q;
  end

  // Handshake decode and next-state for pointers, level, beat half and burst count
  always_comb begin
    full     = (level_q == FULL_LEVEL);
    beat_acc = m_tvalid && m_tready;
    pop      = beat_acc && half_q;
    // A full FIFO still takes a word if the head leaves in the same cycle
    push     = ap_ce && c_data_available && (!full || pop);

    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    half_d   = half_q;
    rcnt_d   = rcnt_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (beat_acc) begin
      half_d = !half_q;
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      rcnt_d = (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + RCW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

`ifdef TS_COLLECT_OVF_EN
  // Sticky overflow: a strobe that found the FIFO full with no pop to free a slot
  always_comb begin
    drop  = ap_ce && c_data_available && full && !pop;
    ovf_d = ovf_q || drop;
    ovf   = ovf_q;
  end

  // Overflow flag register, cleared only by reset
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

  // Control state register; push/pop are already gated by ap_ce so state holds when low
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      half_q  <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      half_q  <= half_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Result storage; cleared on reset so m_tdata reads zero afterwards
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= c_data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_result_collector
// Description : Self-checking bench for ts_result_collector. A queue-based
//               reference model predicts stream outputs and level each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_result_collector;

  localparam int DEPTH     = 4;
  localparam int BURST_LEN = 8;

  logic          ap_clk;
  logic          ap_rst;
  logic          ap_ce;
  logic [127:0]  c_data_in;
  logic          c_data_available;
  logic [63:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [2:0]    fifo_level;
`ifdef TS_COLLECT_OVF_EN
  logic          ovf;
`endif

  ts_result_collector #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ap_ce            (ap_ce),
    .c_data_in        (c_data_in),
    .c_data_available (c_data_available),
    .m_tdata          (m_tdata),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tlast          (m_tlast),
    .fifo_level       (fifo_level)
`ifdef TS_COLLECT_OVF_EN
    ,
    .ovf              (ovf)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of whole results, which half is next, results popped so far
  logic [127:0] mq[$];
  bit           mhalf;
  int           popped;
  bit           movf;

  logic         exp_valid;
  logic         exp_last;
  logic [2:0]   exp_level;
  logic [63:0]  exp_data;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    mq.delete();
    mhalf  = 0;
    popped = 0;
    movf   = 0;
  endtask

  // Drive inputs away from the active edge, then predict outputs for this cycle
  task automatic drive(input logic ce, input logic av, input logic [127:0] d, input logic rdy);
    logic [127:0] h;
    @(negedge ap_clk);
    ap_ce            = ce;
    c_data_available = av;
    c_data_in        = d;
    m_tready         = rdy;
    #1;
    exp_valid = ce && (mq.size() != 0);
    exp_level = 3'(mq.size());
    exp_data  = '0;
    exp_last  = 1'b0;
    if (exp_valid) begin
      h         = mq[0];
      exp_data  = mhalf ? h[127:64] : h[63:0];
      exp_last  = mhalf && ((popped % BURST_LEN) == BURST_LEN - 1);
    end
  endtask

  // Advance one clock and apply the stream/FIFO rules to the model
  task automatic tick();
    bit acc, pop, full, push;
    @(posedge ap_clk);
    acc  = ap_ce && (mq.size() != 0) && m_tready;
    pop  = acc && mhalf;
    full = (mq.size() == DEPTH);
    push = ap_ce && c_data_available && (!full || pop);
    if (ap_ce && c_data_available && full && !pop) movf = 1;
    if (acc) begin
      if (mhalf) begin
        void'(mq.pop_front());
        popped++;
      end
      mhalf = !mhalf;
    end
    if (push) mq.push_back(c_data_in);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1; ap_ce = 1'b1; c_data_available = 1'b0; c_data_in = '0; m_tready = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if ({m_tvalid, m_tlast, fifo_level, m_tdata} !== 69'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b l=%b lvl=%0d d=%h, want all zero",
               m_tvalid, m_tlast, fifo_level, m_tdata);
    end
`ifdef TS_COLLECT_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    ap_rst = 1'b0;
  endtask

  task automatic test_single();
    logic [127:0] w;
    w = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, w, 1'b1);
      n_checks++;
      if ({m_tvalid, m_tlast, fifo_level} !== {exp_valid, exp_last, exp_level}) begin
        n_errors++;
        $display("FAIL single_ctl cyc%0d: got v=%b l=%b lvl=%0d want v=%b l=%b lvl=%0d",
                 i, m_tvalid, m_tlast, fifo_level, exp_valid, exp_last, exp_level);
      end
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data) begin
          n_errors++;
          $display("FAIL single_data cyc%0d: got %h want %h", i, m_tdata, exp_data);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (m_tdata !== 64'h2222_2222_2222_2222 || m_tvalid !== 1'b1) begin
          n_errors++;
          $display("FAIL single_low: got v=%b d=%h want v=1 d=2222222222222222", m_tvalid, m_tdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_burst();
    int beat, nlast, last0, last1;
    do_reset();
    beat = 0; nlast = 0; last0 = 0; last1 = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i % 2 == 0) && (i < 32), rand128(), 1'b1);
      n_checks++;
      if ({m_tvalid, m_tlast, fifo_level} !== {exp_valid, exp_last, exp_level}) begin
        n_errors++;
        $display("FAIL burst_ctl cyc%0d: got v=%b l=%b lvl=%0d want v=%b l=%b lvl=%0d",
                 i, m_tvalid, m_tlast, fifo_level, exp_valid, exp_last, exp_level);
      end
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data) begin
          n_errors++;
          $display("FAIL burst_data cyc%0d: got %h want %h", i, m_tdata, exp_data);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        beat++;
        if (m_tlast === 1'b1) begin
          nlast++;
          if (nlast == 1) last0 = beat; else last1 = beat;
        end
      end
      tick();
    end
    n_checks++;
    if (nlast != 2 || last0 != 16 || last1 != 32 || beat != 32) begin
      n_errors++;
      $display("FAIL burst_framing: got beats=%0d lasts=%0d at %0d,%0d want beats=32 lasts=2 at 16,32",
               beat, nlast, last0, last1);
    end
  endtask

  task automatic test_backpressure();
    int beats;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, rand128(), 1'b0);
      if (i == 4) begin
        n_checks++;
        if (fifo_level !== 3'd4) begin
          n_errors++;
          $display("FAIL bp_full_level: got %0d want 4", fifo_level);
        end
      end
      tick();
    end
`ifdef TS_COLLECT_OVF_EN
    #1;
    n_checks++;
    if (ovf !== 1'b1 || movf != 1) begin
      n_errors++;
      $display("FAIL bp_ovf: got %b want 1", ovf);
    end
`endif
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      n_checks++;
      if ({m_tvalid, m_tlast, fifo_level} !== {exp_valid, exp_last, exp_level}) begin
        n_errors++;
        $display("FAIL bp_ctl cyc%0d: got v=%b l=%b lvl=%0d want v=%b l=%b lvl=%0d",
                 i, m_tvalid, m_tlast, fifo_level, exp_valid, exp_last, exp_level);
      end
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data) begin
          n_errors++;
          $display("FAIL bp_data cyc%0d: got %h want %h", i, m_tdata, exp_data);
        end
      end
      if (m_tvalid === 1'b1) beats++;
      tick();
    end
    n_checks++;
    if (beats != 8) begin
      n_errors++;
      $display("FAIL bp_beats: got %0d want 8", beats);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, rand128(), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b1);   // low beat of head
    tick();
    drive(1'b1, 1'b1, rand128(), 1'b1);   // high beat pops while a new word arrives
    tick();
    drive(1'b1, 1'b0, '0, 1'b0);
    n_checks++;
    if (fifo_level !== 3'd4 || exp_level != 3'd4) begin
      n_errors++;
      $display("FAIL fullpop_level: got %0d want 4", fifo_level);
    end
`ifdef TS_COLLECT_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
`endif
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data || m_tlast !== exp_last) begin
          n_errors++;
          $display("FAIL fullpop_drain cyc%0d: got d=%h l=%b want d=%h l=%b",
                   i, m_tdata, m_tlast, exp_data, exp_last);
        end
      end
      tick();
    end
  endtask

  task automatic test_ce_gating();
    logic [127:0] w;
    w = rand128();
    do_reset();
    drive(1'b1, 1'b1, w, 1'b1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b1);   // low beat accepted
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, rand128(), 1'b1);
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || fifo_level !== 3'd1) begin
        n_errors++;
        $display("FAIL ce_low cyc%0d: got v=%b l=%b lvl=%0d want v=0 l=0 lvl=1",
                 i, m_tvalid, m_tlast, fifo_level);
      end
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b1);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== w[127:64] || exp_data !== w[127:64]) begin
      n_errors++;
      $display("FAIL ce_resume: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, w[127:64]);
    end
    tick();
    drive(1'b1, 1'b0, '0, 1'b1);
    n_checks++;
    if (m_tvalid !== 1'b0 || fifo_level !== 3'd0) begin
      n_errors++;
      $display("FAIL ce_empty: got v=%b lvl=%0d want v=0 lvl=0", m_tvalid, fifo_level);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 8) != 0, ($urandom % 3) == 0, rand128(), ($urandom % 4) != 0);
      n_checks++;
      if ({m_tvalid, m_tlast, fifo_level} !== {exp_valid, exp_last, exp_level}) begin
        n_errors++;
        $display("FAIL rand_ctl cyc%0d: got v=%b l=%b lvl=%0d want v=%b l=%b lvl=%0d",
                 i, m_tvalid, m_tlast, fifo_level, exp_valid, exp_last, exp_level);
      end
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data) begin
          n_errors++;
          $display("FAIL rand_data cyc%0d: got %h want %h", i, m_tdata, exp_data);
        end
      end
      tick();
    end
`ifdef TS_COLLECT_OVF_EN
    #1;
    n_checks++;
    if (ovf !== movf) begin n_errors++; $display("FAIL rand_ovf: got %b want %b", ovf, movf); end
`endif
  endtask

  task automatic test_async_reset();
    int beat, last_at, nlast;
    do_reset();
    // Advance the burst phase first so a surviving rcnt would be visible
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i < 3, rand128(), 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, rand128(), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, '0, 1'b0);
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if ({m_tvalid, m_tlast, fifo_level, m_tdata} !== 69'd0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b l=%b lvl=%0d d=%h want all zero",
               m_tvalid, m_tlast, fifo_level, m_tdata);
    end
    #1;
    ap_rst = 1'b0;
    model_clear();
    tick();
    beat = 0; last_at = 0; nlast = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2 == 0) && (i < 16), rand128(), 1'b1);
      if (exp_valid) begin
        n_checks++;
        if (m_tdata !== exp_data || m_tlast !== exp_last) begin
          n_errors++;
          $display("FAIL rst_restart cyc%0d: got d=%h l=%b want d=%h l=%b",
                   i, m_tdata, m_tlast, exp_data, exp_last);
        end
      end
      if (m_tvalid === 1'b1) begin
        beat++;
        if (m_tlast === 1'b1) begin nlast++; last_at = beat; end
      end
      tick();
    end
    n_checks++;
    if (nlast != 1 || last_at != 16) begin
      n_errors++;
      $display("FAIL rst_burst_phase: got lasts=%0d at beat %0d want 1 at beat 16", nlast, last_at);
    end
  endtask

  initial begin
    ap_rst = 1'b0; ap_ce = 1'b0; c_data_available = 1'b0; c_data_in = '0; m_tready = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full_pop();
    test_ce_gating();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
